// File: rtl/fetch_ctrl.sv
// Multicycle instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// presents each fetched instruction to decode and applies execute-stage redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCsrc,
    input  logic [31:0] PCtarget,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] PC
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        drop;
    logic [31:0] redir_pc;
    logic [31:0] target_aligned;

    assign target_aligned = {PCtarget[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ:  state_nxt = imem_gnt ? WAIT : REQ;
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = (drop || PCsrc) ? REQ : OUT;
                end
            end
            OUT:  state_nxt = (PCsrc || !stall) ? REQ : OUT;
            default: state_nxt = IDLE;
        endcase
    end

    // Request and address are held stable in REQ until granted, even across redirects.
    always_comb begin
        imem_req  = (state == REQ);
        imem_addr = PC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PC          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            drop        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (PCsrc) begin
                        PC <= target_aligned;
                    end
                end
                REQ: begin
                    if (PCsrc) begin
                        drop <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (drop || PCsrc) begin
                            // Stale response: the PC jumps only now, to the newest target.
                            PC   <= PCsrc ? target_aligned : redir_pc;
                            drop <= 1'b0;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= PC;
                            PC          <= PC + 32'd4;
                            instr_valid <= 1'b1;
                        end
                    end else if (PCsrc) begin
                        drop <= 1'b1;
                    end
                end
                OUT: begin
                    if (PCsrc) begin
                        instr_valid <= 1'b0;
                        PC          <= target_aligned;
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pending redirect target; only meaningful while drop is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (PCsrc && (state == REQ || (state == WAIT && !imem_rvalid))) begin
            redir_pc <= target_aligned;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus queues expected instructions, a monitor
// pops and checks them whenever decode sees a new instruction.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCsrc;
    logic [31:0] PCtarget;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] PC;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic vld_q  = 1'b0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .PCsrc      (PCsrc),
        .PCtarget   (PCtarget),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .PC         (PC)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starting in REQ at the given address: grant at once, respond the next cycle.
    task automatic fetch(input logic [31:0] data, input logic [31:0] addr);
        exp_t e;
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, addr);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("wait_req_low", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        e.instr = data;
        e.pc    = addr;
        exp_q.push_back(e);
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    // Scoreboard monitor: every new instruction presented to decode must be expected.
    always @(negedge clk) begin
        exp_t e;
        if (instr_valid === 1'b1 && vld_q !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got instr 0x%08h pc 0x%08h, expected no instruction", instr, instr_pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_instr", instr, e.instr);
                check("sb_pc", instr_pc, e.pc);
            end
        end
        vld_q = instr_valid;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        PCsrc       = 1'b0;
        PCtarget    = 32'h0;
        stall       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        step();
        step();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_pc", PC, 32'h0);
        reset = 1'b0;
        step();

        // T1: basic fetch from reset PC
        fetch(32'h0050_0093, 32'h0);
        check("t1_valid", 32'(instr_valid), 32'd1);
        check("t1_pc_inc", PC, 32'h4);
        step();
        check("t1_valid_drop", 32'(instr_valid), 32'd0);
        check("t1_next_addr", imem_addr, 32'h4);

        // T2: redirect while the request is waiting for grant
        PCsrc    = 1'b1;
        PCtarget = 32'h40;
        check("t2_addr0", imem_addr, 32'h4);
        step();
        PCsrc    = 1'b0;
        PCtarget = 32'h0;
        for (int i = 0; i < 2; i++) begin
            check("t2_req_hold", 32'(imem_req), 32'd1);
            check("t2_addr_hold", imem_addr, 32'h4);
            check("t2_pc_hold", PC, 32'h4);
            step();
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("t2_no_valid", 32'(instr_valid), 32'd0);
        check("t2_req", 32'(imem_req), 32'd1);
        check("t2_addr", imem_addr, 32'h40);

        // T3: decode stalls for three cycles
        fetch(32'h00A0_0113, 32'h40);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t3_valid", 32'(instr_valid), 32'd1);
            check("t3_instr", instr, 32'h00A0_0113);
            check("t3_instr_pc", instr_pc, 32'h40);
            check("t3_req_low", 32'(imem_req), 32'd0);
            step();
        end
        stall = 1'b0;
        check("t3_still_valid", 32'(instr_valid), 32'd1);
        step();
        check("t3_resume_req", 32'(imem_req), 32'd1);
        check("t3_resume_addr", imem_addr, 32'h44);

        // T4: redirect during a stalled output, unaligned target
        fetch(32'h0000_0013, 32'h44);
        stall    = 1'b1;
        PCsrc    = 1'b1;
        PCtarget = 32'h23;
        step();
        stall    = 1'b0;
        PCsrc    = 1'b0;
        check("t4_valid", 32'(instr_valid), 32'd0);
        check("t4_addr", imem_addr, 32'h20);

        // T5a: two redirects in WAIT, latest wins
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        PCsrc    = 1'b1;
        PCtarget = 32'h80;
        step();
        PCtarget = 32'h100;
        step();
        PCsrc       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        step();
        imem_rvalid = 1'b0;
        check("t5a_valid", 32'(instr_valid), 32'd0);
        check("t5a_addr", imem_addr, 32'h100);

        // T5b: redirect on the same cycle as rvalid
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2222_2222;
        PCsrc       = 1'b1;
        PCtarget    = 32'h200;
        step();
        imem_rvalid = 1'b0;
        PCsrc       = 1'b0;
        check("t5b_valid", 32'(instr_valid), 32'd0);
        check("t5b_addr", imem_addr, 32'h200);

        // T6: PC wraps at the top of the address space, then reset mid-WAIT
        fetch(32'h3333_3333, 32'h200);
        PCsrc    = 1'b1;
        PCtarget = 32'hFFFF_FFFE;
        step();
        PCsrc    = 1'b0;
        fetch(32'h1234_5678, 32'hFFFF_FFFC);
        check("t6_wrap_pc", PC, 32'h0);
        step();
        check("t6_wrap_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        reset    = 1'b1;
        step();
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h4444_4444;
        check("t6_rst_req", 32'(imem_req), 32'd0);
        check("t6_rst_valid", 32'(instr_valid), 32'd0);
        check("t6_rst_instr", instr, 32'h0);
        check("t6_rst_instr_pc", instr_pc, 32'h0);
        check("t6_rst_pc", PC, 32'h0);
        step();
        imem_rvalid = 1'b0;
        check("t6_ignored_valid", 32'(instr_valid), 32'd0);
        fetch(32'h0010_0093, 32'h0);
        step();
        check("t6_restart_addr", imem_addr, 32'h4);

        step();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
